// File: rtl/clock_divisor_ramp_ctrl_if.sv
// Command port of the divisor ramp controller: a target divisor handshake
// plus the completion pulse.
interface clock_divisor_ramp_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_target;
  logic             cmd_done;

  modport master (
    output cmd_valid,
    output cmd_target,
    input  cmd_ready,
    input  cmd_done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    output cmd_ready,
    output cmd_done
  );
endinterface

// File: rtl/clock_divisor_ramp_ctrl.sv
// Ramps the divider's divisor toward a commanded target in bounded steps,
// applying each step only right after the divided clock toggles.
module clock_divisor_ramp_ctrl #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned INIT_DIV = 1000,
  parameter int unsigned STEP     = 1,
  parameter int unsigned DWELL    = 2,
  parameter int unsigned MIN_DIV  = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        clk_div_in,
  clock_divisor_ramp_ctrl_if.slave    cmd,
  output logic [WIDTH-1:0]            divisor_out,
  output logic                        div_rst,
  output logic                        busy
);

  typedef enum logic [1:0] {ST_OFF, ST_IDLE, ST_DWELL} state_e;

  localparam int unsigned    CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]  DWELL_LAST = CW'(DWELL - 1);
  localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] INIT_W   = WIDTH'(INIT_DIV);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  div_q, div_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic [CW-1:0]     dwell_q, dwell_d;
  logic              done_q, done_d;
  logic              prev_q;

  logic              tog;
  logic              up;
  logic [WIDTH-1:0]  diff;
  logic [WIDTH-1:0]  amt;
  logic [WIDTH-1:0]  stepped;
  logic [WIDTH-1:0]  cmd_clamped;

  // tog is high the cycle after the divider toggles, when its counter is <= 1
  assign tog         = clk_div_in ^ prev_q;
  assign up          = target_q > div_q;
  assign diff        = up ? (target_q - div_q) : (div_q - target_q);
  assign amt         = (diff < STEP_W) ? diff : STEP_W;
  assign stepped     = up ? (div_q + amt) : (div_q - amt);
  assign cmd_clamped = (cmd.cmd_target < MIN_W) ? MIN_W : cmd.cmd_target;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_OFF;
      div_q    <= INIT_W;
      target_q <= '0;
      dwell_q  <= '0;
      done_q   <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      target_q <= target_d;
      dwell_q  <= dwell_d;
      done_q   <= done_d;
      prev_q   <= clk_div_in;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    target_d = target_q;
    dwell_d  = dwell_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (en) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!en) begin
          state_d = ST_OFF;
        end else if (cmd.cmd_valid) begin
          target_d = cmd_clamped;
          dwell_d  = '0;
          if (cmd_clamped == div_q) done_d  = 1'b1;
          else                      state_d = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (!en) begin
          state_d = ST_OFF;
        end else if (tog) begin
          if (dwell_q == DWELL_LAST) begin
            div_d   = stepped;
            dwell_d = '0;
            if (stepped == target_q) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            dwell_d = dwell_q + CW'(1);
          end
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign cmd.cmd_done  = done_q;
  assign busy          = (state_q == ST_DWELL);
  assign div_rst       = (state_q == ST_OFF);
  assign divisor_out   = div_q;

endmodule

// File: tb/tb_clock_divisor_ramp_ctrl.sv
// Bench for clock_divisor_ramp_ctrl: directed ramp table, abort and async
// reset sequences, and random-toggle ramps against a step-list model.
module tb_clock_divisor_ramp_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clk_div_in;
  logic [31:0] divisor_out;
  logic        div_rst;
  logic        busy;

  logic        use_man;
  logic        man_clk;
  logic        mdl_clk;
  logic [31:0] mcnt;
  int          overrun;
  logic        pre_last;
  logic        pre_prev;

  int errors;
  int checks;

  clock_divisor_ramp_ctrl_if #(.WIDTH(32)) cmd_if ();

  clock_divisor_ramp_ctrl #(
    .WIDTH   (32),
    .INIT_DIV(10),
    .STEP    (2),
    .DWELL   (1),
    .MIN_DIV (4)
  ) dut (
    .clk_in     (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clk_div_in (clk_div_in),
    .cmd        (cmd_if.slave),
    .divisor_out(divisor_out),
    .div_rst    (div_rst),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign clk_div_in = use_man ? man_clk : mdl_clk;

  // Behavioural divider: toggles its output every divisor_out cycles.
  always @(posedge clk) begin
    if (!div_rst && !use_man && mcnt > divisor_out) overrun = overrun + 1;
    if (div_rst || use_man) begin
      mcnt    <= '0;
      mdl_clk <= 1'b0;
    end else if (mcnt >= divisor_out - 1) begin
      mcnt    <= '0;
      mdl_clk <= ~mdl_clk;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one clock; remember what clk_div_in the DUT sampled at each edge.
  task automatic tick();
    if (use_man && ($urandom_range(0, 2) == 0)) man_clk = ~man_clk;
    pre_prev = pre_last;
    pre_last = use_man ? man_clk : mdl_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic run_ramp(input logic [31:0] tgt, input bit rnd,
                          output int nsteps, output logic [31:0] fin);
    logic [31:0] q[$];
    logic [31:0] t, v, cur;
    int          budget;
    bit          tg;
    cur = divisor_out;
    t   = (tgt < 4) ? 32'd4 : tgt;
    v   = cur;
    while (v != t) begin
      if (v < t) v = (t - v > 2) ? v + 2 : t;
      else       v = (v - t > 2) ? v - 2 : t;
      q.push_back(v);
    end
    nsteps = 0;
    chk("ready_before_cmd", {31'd0, cmd_if.cmd_ready}, 1);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = tgt;
    tick();
    cmd_if.cmd_valid = 1'b0;
    if (q.size() == 0) begin
      chk("noop_done", {31'd0, cmd_if.cmd_done}, 1);
      chk("noop_busy", {31'd0, busy}, 0);
      chk("noop_div", divisor_out, cur);
    end else begin
      chk("accept_busy", {31'd0, busy}, 1);
      chk("accept_done", {31'd0, cmd_if.cmd_done}, 0);
      chk("accept_div", divisor_out, cur);
      budget = 600;
      while (q.size() > 0 && budget > 0) begin
        if (rnd) begin
          cmd_if.cmd_valid  = 1'($urandom_range(0, 1));
          cmd_if.cmd_target = $urandom_range(0, 40);
        end
        tick();
        budget--;
        tg = pre_last ^ pre_prev;
        if (tg) begin
          v = q.pop_front();
          nsteps++;
          chk("step_div", divisor_out, v);
          chk("step_done", {31'd0, cmd_if.cmd_done}, (q.size() == 0) ? 1 : 0);
          chk("step_busy", {31'd0, busy}, (q.size() != 0) ? 1 : 0);
          cur = v;
        end else begin
          chk("hold_div", divisor_out, cur);
          chk("hold_done", {31'd0, cmd_if.cmd_done}, 0);
          chk("hold_busy", {31'd0, busy}, 1);
        end
      end
      cmd_if.cmd_valid = 1'b0;
      if (q.size() != 0) chk("ramp_timeout", q.size(), 0);
    end
    fin = divisor_out;
    tick();
    chk("done_one_cycle", {31'd0, cmd_if.cmd_done}, 0);
    chk("idle_ready", {31'd0, cmd_if.cmd_ready}, 1);
    chk("idle_busy", {31'd0, busy}, 0);
  endtask

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] fin;
    int          steps;
  } vec_t;

  vec_t        tbl[7];
  int          n;
  logic [31:0] f;
  logic [31:0] rt;
  int          budget;

  initial begin
    errors = 0; checks = 0; overrun = 0;
    rst_n = 1'b0; en = 1'b0; use_man = 1'b0; man_clk = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_target = '0;
    pre_last = 1'b0; pre_prev = 1'b0;

    // From divisor 10: no-op, up, down, clamped down, clamped no-ops, up.
    tbl[0] = '{tgt: 32'd10, fin: 32'd10, steps: 0};
    tbl[1] = '{tgt: 32'd15, fin: 32'd15, steps: 3};
    tbl[2] = '{tgt: 32'd10, fin: 32'd10, steps: 3};
    tbl[3] = '{tgt: 32'd1,  fin: 32'd4,  steps: 3};
    tbl[4] = '{tgt: 32'd4,  fin: 32'd4,  steps: 0};
    tbl[5] = '{tgt: 32'd2,  fin: 32'd4,  steps: 0};
    tbl[6] = '{tgt: 32'd10, fin: 32'd10, steps: 3};

    #12;
    chk("rst_div", divisor_out, 10);
    chk("rst_div_rst", {31'd0, div_rst}, 1);
    chk("rst_ready", {31'd0, cmd_if.cmd_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, cmd_if.cmd_done}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("off_div_rst", {31'd0, div_rst}, 1);
    chk("off_ready", {31'd0, cmd_if.cmd_ready}, 0);
    en = 1'b1;
    tick();
    chk("en_div_rst", {31'd0, div_rst}, 0);
    chk("en_ready", {31'd0, cmd_if.cmd_ready}, 1);

    for (int i = 0; i < 7; i++) begin
      run_ramp(tbl[i].tgt, 1'b0, n, f);
      chk("tbl_final", f, tbl[i].fin);
      chk("tbl_steps", n, tbl[i].steps);
    end
    chk("divider_overrun", overrun, 0);

    // Abort a ramp to 20 once the first step (12) has landed.
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = 32'd20;
    tick();
    cmd_if.cmd_valid = 1'b0;
    budget = 200;
    while (divisor_out != 12 && budget > 0) begin
      tick();
      budget--;
    end
    chk("abort_reach12", divisor_out, 12);
    en = 1'b0;
    tick();
    chk("abort_div", divisor_out, 12);
    chk("abort_div_rst", {31'd0, div_rst}, 1);
    chk("abort_ready", {31'd0, cmd_if.cmd_ready}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, cmd_if.cmd_done}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_hold_div", divisor_out, 12);
      chk("abort_hold_done", {31'd0, cmd_if.cmd_done}, 0);
    end
    en = 1'b1;
    tick();
    chk("reen_ready", {31'd0, cmd_if.cmd_ready}, 1);
    chk("reen_div_rst", {31'd0, div_rst}, 0);

    // Asynchronous reset between clock edges during a ramp.
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = 32'd20;
    tick();
    cmd_if.cmd_valid = 1'b0;
    tick();
    tick();
    chk("async_pre_busy", {31'd0, busy}, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_div", divisor_out, 10);
    chk("async_div_rst", {31'd0, div_rst}, 1);
    chk("async_busy", {31'd0, busy}, 0);
    chk("async_ready", {31'd0, cmd_if.cmd_ready}, 0);
    chk("async_done", {31'd0, cmd_if.cmd_done}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pre_last = 1'b0;
    pre_prev = 1'b0;
    tick();
    chk("post_async_ready", {31'd0, cmd_if.cmd_ready}, 1);

    // Random targets with randomly timed divided-clock toggles.
    man_clk = 1'b0;
    use_man = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rt = $urandom_range(0, 24);
      run_ramp(rt, 1'b1, n, f);
      chk("rand_final", f, (rt < 4) ? 32'd4 : rt);
    end
    man_clk = 1'b0;
    use_man = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_divisor_ramp_ctrl.md
Name: clock_divisor_ramp_ctrl

Overview:
Sequencer for the programmable clock divider in the DSP controller. It accepts a target divisor over a valid/ready command port and ramps the divider's divisor toward it in bounded steps. Each step is applied only just after the divided clock toggles, so the divider's counter can never be left above its divisor. It also holds the divider in reset while the controller is disabled.

Parameters:
WIDTH, 32, divisor width; matches the divider's divisor input.
INIT_DIV, 1000, divisor_out value after reset.
STEP, 1, maximum change of divisor_out per applied step; must be >= 1.
DWELL, 2, number of clk_div_in toggles observed between applied steps; must be >= 1.
MIN_DIV, 4, lowest divisor ever driven; command targets below this are clamped up to it.

Ports:
clk_in  input  1  system clock; the same clock that drives the divider.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  controller enable; low forces the OFF state.
cmd_valid  input  1  target command valid.
cmd_ready  output  1  controller can accept a command.
cmd_target  input  WIDTH  requested divisor.
cmd_done  output  1  one-cycle pulse: divisor_out has reached the latched target.
clk_div_in  input  1  divided clock fed back from the divider output.
divisor_out  output  WIDTH  divisor driven to the divider.
div_rst  output  1  active-high synchronous reset driven to the divider.
busy  output  1  a ramp is in progress.

Behaviour:
- Reset (asynchronous, rst_n low), regardless of state or clock:
  - state=OFF, divisor_out=INIT_DIV, div_rst=1.
  - cmd_ready=0, cmd_done=0, busy=0.
  - Internal registers cleared: target, dwell_cnt, clk_div_prev.
- Toggle detect:
  - clk_div_prev is a register that samples clk_div_in every cycle.
  - tog = clk_div_in XOR clk_div_prev (combinational).
  - tog is high in the cycle after the divider toggles. At that point the divider counter is <= 1, so any divisor >= MIN_DIV is safe to load.
- States: OFF, IDLE, DWELL.
- OFF:
  - div_rst=1, cmd_ready=0, busy=0; divisor_out holds its value.
  - en=1 -> IDLE on the next edge. div_rst deasserts on that same edge.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid & cmd_ready: target <= max(cmd_target, MIN_DIV).
  - If the clamped target equals divisor_out: cmd_done pulses on the next cycle and the state stays IDLE.
  - Otherwise: go to DWELL with dwell_cnt=0.
- DWELL:
  - cmd_ready=0, busy=1. cmd_valid is ignored; nothing is queued.
  - On each tog: if dwell_cnt < DWELL-1, dwell_cnt increments.
  - On a tog with dwell_cnt == DWELL-1, apply one step (registered, visible the next cycle) and set dwell_cnt=0:
    - If target > divisor_out: divisor_out += min(STEP, target - divisor_out).
    - Otherwise: divisor_out -= min(STEP, divisor_out - target).
    - Width rule: the differences are computed in WIDTH bits and the result never passes the target, so there is no overflow or underflow.
  - If the stepped value equals target: cmd_done pulses in the same cycle the new divisor_out appears, and the next state is IDLE.
  - If clk_div_in never toggles: the controller stays in DWELL indefinitely; dropping en is the escape.
- en low in IDLE or DWELL:
  - Next state is OFF and div_rst=1 on the next edge.
  - divisor_out keeps its last applied value.
  - The ramp is abandoned and cmd_done does not pulse.
- Simultaneous events:
  - en low wins over tog and over cmd_valid in the same cycle.
  - In IDLE, a cmd_valid handshake in the cycle en rises is not possible, because cmd_ready=0 while in OFF.
- cmd_done is never high for more than one cycle. cmd_done and busy are never high in the same cycle after the state reaches IDLE.

Test Plan:
- Bench setup: WIDTH=32, INIT_DIV=10, STEP=2, DWELL=1, MIN_DIV=4. A behavioural divider model is driven by divisor_out and div_rst.
- Reset and enable: hold rst_n=0 -> divisor_out=10, div_rst=1, cmd_ready=0. Release rst_n, then set en=1 -> div_rst=0 and cmd_ready=1 one cycle later.
- Ramp up: cmd_target=15 -> divisor_out goes 12, 14, 15, each one cycle after a clk_div_in toggle. cmd_done pulses once with 15; busy is high throughout.
- Ramp down with clamp: cmd_target=1 from 10 -> divisor_out goes 8, 6, 4 and stops at 4; cmd_done pulses. The divider model's counter never exceeds its divisor.
- No-op command: cmd_target=10 with divisor_out=10 -> cmd_done one cycle after the handshake, busy stays 0, divisor_out unchanged.
- Abort: drop en after divisor_out=12 during a ramp to 20 -> next cycle state=OFF, div_rst=1, divisor_out=12, no cmd_done. Re-enable -> cmd_ready=1.
- Async reset: assert rst_n=0 mid-ramp between clock edges -> outputs take reset values immediately (divisor_out=10, div_rst=1, busy=0).
